// File: rtl/nios_dmem_responder.sv
// nios_dmem_responder: word RAM serving nios_2 stw/ldw on the data_mem_* bus, with post-reset clear sequencer.
// Optional statistics counters are enabled by defining DMEM_STATS_EN; otherwise the counter ports read 0.
module nios_dmem_responder #(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_mem_wr_i,
  input  logic        data_mem_rd_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [31:0] data_mem_wdata_i,
  output logic [31:0] data_mem_rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        err_sticky_o,
  input  logic        clr_err_i,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o,
  output logic [15:0] err_cnt_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_ready;
  logic              r_err;
  logic              r_sticky;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH];
  logic              w_req;
  logic              w_bad_addr;
  logic              w_init;
  logic              w_err;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_idx;
  assign w_req      = data_mem_rd_i | data_mem_wr_i;
  assign w_idx      = data_mem_addr_i[ADDR_W+1:2];
  assign w_bad_addr = (data_mem_addr_i[1:0] != 2'b00) || (data_mem_addr_i[31:ADDR_W+2] != '0);
  assign w_init     = (r_state == INIT);
  assign w_err      = w_req && (w_bad_addr || w_init || (data_mem_rd_i && data_mem_wr_i));
  // A simultaneous rd+wr still writes; only address faults and INIT suppress the write
  assign w_wr_en    = data_mem_wr_i && !w_init && !w_bad_addr;
  // Clear sequencer plus registered ready and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= INIT;
      r_ptr    <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if (r_state == INIT) begin
        r_ptr <= r_ptr + 1'b1;
        if (&r_ptr) begin
          r_state <= RUN;
          r_ready <= 1'b1;
        end
      end
      r_err    <= w_err;
      r_sticky <= w_err ? 1'b1 : (clr_err_i ? 1'b0 : r_sticky);
    end
  end
  // RAM array: clear writes own the port during INIT
  always_ff @(posedge clk) begin
    if (w_init) r_mem[r_ptr] <= '0;
    else if (w_wr_en) r_mem[w_idx] <= data_mem_wdata_i;
  end
  // Read register: returns pre-write contents; address faults and INIT load zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rdata <= '0;
    else if (data_mem_rd_i) r_rdata <= (w_bad_addr || w_init) ? '0 : r_mem[w_idx];
  end
  assign data_mem_rdata_o = r_rdata;
  assign ready_o          = r_ready;
  assign err_o            = r_err;
  assign err_sticky_o     = r_sticky;
`ifdef DMEM_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;
  logic [15:0] r_err_cnt;
  logic        w_rd_ok;
  logic        w_wr_ok;
  assign w_rd_ok = data_mem_rd_i && !w_err;
  assign w_wr_ok = data_mem_wr_i && !w_err;
  // Saturating access/error statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_rd_cnt  <= r_rd_cnt + {15'b0, w_rd_ok && (r_rd_cnt != 16'hFFFF)};
      r_wr_cnt  <= r_wr_cnt + {15'b0, w_wr_ok && (r_wr_cnt != 16'hFFFF)};
      r_err_cnt <= r_err_cnt + {15'b0, w_err && (r_err_cnt != 16'hFFFF)};
    end
  end
  assign rd_cnt_o  = r_rd_cnt;
  assign wr_cnt_o  = r_wr_cnt;
  assign err_cnt_o = r_err_cnt;
`else
  assign rd_cnt_o  = '0;
  assign wr_cnt_o  = '0;
  assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_nios_dmem_responder.sv
// tb_nios_dmem_responder: directed plus random checks of nios_dmem_responder against a word-array reference model.
module tb_nios_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_mem_wr_i;
  logic        data_mem_rd_i;
  logic [31:0] data_mem_addr_i;
  logic [31:0] data_mem_wdata_i;
  logic [31:0] data_mem_rdata_o;
  logic        ready_o;
  logic        err_o;
  logic        err_sticky_o;
  logic        clr_err_i;
  logic [15:0] rd_cnt_o;
  logic [15:0] wr_cnt_o;
  logic [15:0] err_cnt_o;

  nios_dmem_responder #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .data_mem_wr_i(data_mem_wr_i), .data_mem_rd_i(data_mem_rd_i),
    .data_mem_addr_i(data_mem_addr_i), .data_mem_wdata_i(data_mem_wdata_i),
    .data_mem_rdata_o(data_mem_rdata_o), .ready_o(ready_o),
    .err_o(err_o), .err_sticky_o(err_sticky_o), .clr_err_i(clr_err_i),
    .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_m [64];
  int          init_left;
  logic [31:0] rdata_m;
  logic        err_m;
  logic        sticky_m;
  int          rdc_m, wrc_m, errc_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("rdata", data_mem_rdata_o, rdata_m);
    chk("err", {31'b0, err_o}, {31'b0, err_m});
    chk("sticky", {31'b0, err_sticky_o}, {31'b0, sticky_m});
    chk("ready", {31'b0, ready_o}, {31'b0, init_left == 0});
    chk("rd_cnt", {16'b0, rd_cnt_o}, rdc_m);
    chk("wr_cnt", {16'b0, wr_cnt_o}, wrc_m);
    chk("err_cnt", {16'b0, err_cnt_o}, errc_m);
  endtask

  // Called at posedge+1: asserts reset, checks reset values, releases it just after the next edge
  task automatic do_reset();
    data_mem_rd_i = 1'b0; data_mem_wr_i = 1'b0; clr_err_i = 1'b0;
    data_mem_addr_i = '0; data_mem_wdata_i = '0;
    rst = 1'b0;
    init_left = 64; rdata_m = '0; err_m = 1'b0; sticky_m = 1'b0;
    rdc_m = 0; wrc_m = 0; errc_m = 0;
    @(posedge clk); #1;
    check_all();
    rst = 1'b1;
  endtask

  // One bus cycle: drive request, advance model, clock, optionally compare everything
  task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic c, input bit do_chk);
    logic bad, in_init, e;
    int idx;
    data_mem_rd_i = r; data_mem_wr_i = w; data_mem_addr_i = a; data_mem_wdata_i = d; clr_err_i = c;
    bad     = (a % 4 != 0) || (a >= 256);
    in_init = init_left > 0;
    e       = (r || w) && (bad || in_init || (r && w));
    idx     = (a / 4) % 64;
    if (r) rdata_m = (bad || in_init) ? 32'h0 : mem_m[idx];
    if (w && !bad && !in_init) mem_m[idx] = d;
    err_m = e;
    sticky_m = e ? 1'b1 : (c ? 1'b0 : sticky_m);
`ifdef DMEM_STATS_EN
    if (r && !e && rdc_m < 65535) rdc_m++;
    if (w && !e && wrc_m < 65535) wrc_m++;
    if (e && errc_m < 65535) errc_m++;
`endif
    if (in_init) begin
      init_left--;
      if (init_left == 0) foreach (mem_m[i]) mem_m[i] = '0;
    end
    @(posedge clk); #1;
    data_mem_rd_i = 1'b0; data_mem_wr_i = 1'b0; clr_err_i = 1'b0;
    if (do_chk) check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    logic r, w;
    @(posedge clk); #1;
    do_reset();
    idle(64);
    chk("ready_after_64", {31'b0, ready_o}, 32'h1);

    // Write then read on the next cycle
    cycle(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    chk("wr_rd_data", data_mem_rdata_o, 32'hDEADBEEF);
    chk("wr_rd_err", {31'b0, err_o}, 32'h0);
`ifdef DMEM_STATS_EN
    chk("wr_cnt_1", {16'b0, wr_cnt_o}, 32'h1);
    chk("rd_cnt_1", {16'b0, rd_cnt_o}, 32'h1);
`endif
    cycle(1'b1, 1'b0, 32'h00, 32'h0, 1'b0, 1'b1);
    chk("init_zero_0", data_mem_rdata_o, 32'h0);
    cycle(1'b1, 1'b0, 32'hFC, 32'h0, 1'b0, 1'b1);
    chk("init_zero_fc", data_mem_rdata_o, 32'h0);

    // Misaligned write is dropped; out-of-range read loads zero
    cycle(1'b0, 1'b1, 32'h12, 32'h12345678, 1'b0, 1'b1);
    chk("misal_err", {31'b0, err_o}, 32'h1);
    chk("misal_sticky", {31'b0, err_sticky_o}, 32'h1);
    cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    chk("misal_kept", data_mem_rdata_o, 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1);
    chk("oor_data", data_mem_rdata_o, 32'h0);
    chk("oor_err", {31'b0, err_o}, 32'h1);

    // Sticky clear without and with a coincident error
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("sticky_clr", {31'b0, err_sticky_o}, 32'h0);
    cycle(1'b1, 1'b0, 32'h3, 32'h0, 1'b1, 1'b1);
    chk("sticky_set_wins", {31'b0, err_sticky_o}, 32'h1);

    // Simultaneous rd+wr: old data returned, write still lands
    cycle(1'b0, 1'b1, 32'h20, 32'h1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h20, 32'h2, 1'b0, 1'b1);
    chk("dual_data", data_mem_rdata_o, 32'h1);
    chk("dual_err", {31'b0, err_o}, 32'h1);
    cycle(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
    chk("dual_after", data_mem_rdata_o, 32'h2);

    // Reset mid-RUN, then again at INIT cycle 30, with accesses during INIT
    do_reset();
    idle(30);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      a = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      cycle(i % 3 == 0, i % 2 == 0, a, $urandom, 1'b0, 1'b1);
    end
    chk("ready_after_mid_reset", {31'b0, ready_o}, 32'h1);
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      a = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = a | (32'h100 << $urandom_range(0, 23));
      r = $urandom_range(0, 2) != 0;
      w = $urandom_range(0, 2) != 0;
      cycle(r, w, a, $urandom, $urandom_range(0, 3) == 0, 1'b1);
    end

`ifdef DMEM_STATS_EN
    for (int i = 0; i < 70000; i++) cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    check_all();
    chk("rd_cnt_sat", {16'b0, rd_cnt_o}, 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
